// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with a bounded hold time per grant.
// Every release is followed by one dead cycle, and the next winner is chosen in that cycle.
module arb3_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       done,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] owner_nxt;
    logic [1:0] winner;
    logic [7:0] cnt, cnt_nxt;
    logic       timeout_nxt;
    logic       hit_limit;
    logic       holder_req;
    logic [3:0] req_v;

    // Bit 0 is a constant 0, so "no owner" indexes as a non-request.
    assign req_v      = {req3, req2, req1, 1'b0};
    assign hit_limit  = (cnt == LIMIT);
    assign holder_req = req_v[owner];

    // Search starts at the requester after lst, wrapping 3 -> 1. Returns 0 if nobody requests.
    function automatic logic [1:0] rr_pick(input logic [1:0] lst, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = 2'd0;
        idx     = lst;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
            if (rr_pick == 2'd0 && r[idx])
                rr_pick = idx;
        end
    endfunction

    assign winner = rr_pick(last, req_v);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = cnt;
        owner_nxt   = owner;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (winner != 2'd0) begin
                    state_nxt = HOLD;
                    owner_nxt = winner;
                    last_nxt  = winner;
                    cnt_nxt   = 8'd1;
                end
            end
            HOLD: begin
                if (!holder_req || done || hit_limit) begin
                    state_nxt   = IDLE;
                    owner_nxt   = 2'd0;
                    cnt_nxt     = 8'd0;
                    // A limit hit masked by a voluntary release is not reported as a timeout.
                    timeout_nxt = hit_limit && holder_req && !done;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = 2'd0;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            last    <= 2'd3;
            cnt     <= 8'd0;
            owner   <= 2'd0;
            gnt1    <= 1'b0;
            gnt2    <= 1'b0;
            gnt3    <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            gnt1    <= (owner_nxt == 2'd1);
            gnt2    <= (owner_nxt == 2'd2);
            gnt3    <= (owner_nxt == 2'd3);
            busy    <= (owner_nxt != 2'd0);
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_arb3_rr.sv
// Bench for arb3_rr: directed scenarios plus a long random run against a
// transaction-level round-robin reference model.
module tb_arb3_rr;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0, req3 = 1'b0, done = 1'b0;
    logic       gnt1, gnt2, gnt3, busy, timeout;
    logic [1:0] owner;

    int errors = 0;
    int checks = 0;

    // Reference model: who holds the resource, for how long, who won last.
    int m_owner, m_cnt, m_last;
    bit m_to;

    arb3_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rstb(rstb),
        .req1(req1), .req2(req2), .req3(req3), .done(done),
        .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
        .owner(owner), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 3;
        m_to    = 0;
    endtask

    task automatic model_step(input bit [3:1] r, input bit d);
        int cand;
        if (m_owner == 0) begin
            m_to = 0;
            for (int k = 1; k <= 3; k++) begin
                cand = (m_last + k - 1) % 3 + 1;
                if (m_owner == 0 && r[cand]) begin
                    m_owner = cand;
                    m_last  = cand;
                    m_cnt   = 1;
                end
            end
        end else if (!r[m_owner] || d || m_cnt == MAX_HOLD) begin
            m_to    = (m_cnt == MAX_HOLD) && r[m_owner] && !d;
            m_owner = 0;
            m_cnt   = 0;
        end else begin
            m_cnt++;
            m_to = 0;
        end
    endtask

    function automatic logic [6:0] model_outs();
        logic [2:0] g;
        g = 3'b000;
        if (m_owner != 0) g[m_owner-1] = 1'b1;
        return {g, 2'(m_owner), (m_owner != 0), m_to};
    endfunction

    // Apply inputs for one edge, advance the model, sample 1 ns after the edge.
    task automatic drive(input bit [3:1] r, input bit d);
        {req3, req2, req1} = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", {gnt3, gnt2, gnt1}); end
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got=%b exp=00", owner); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rstb = 1'b1;
        // Idle with DONE strobes: nothing may happen.
        drive(3'b000, 1'b1);
        drive(3'b000, 1'b1);
        checks++; if ({gnt3, gnt2, gnt1, owner, busy, timeout} !== 7'b0) begin errors++; $display("FAIL idle_done got=%b exp=0000000", {gnt3, gnt2, gnt1, owner, busy, timeout}); end
    endtask

    task automatic test_hold_limit();
        drive(3'b111, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b001 || owner !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL first_grant got gnt=%b owner=%0d busy=%b exp gnt=001 owner=1 busy=1", {gnt3, gnt2, gnt1}, owner, busy); end
        for (int i = 2; i <= MAX_HOLD; i++) begin
            drive(3'b111, 1'b0);
            checks++; if ({gnt3, gnt2, gnt1} !== 3'b001 || timeout !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d got gnt=%b to=%b exp gnt=001 to=0", i, {gnt3, gnt2, gnt1}, timeout); end
        end
        drive(3'b111, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b000 || busy !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL limit_release got gnt=%b busy=%b to=%b exp gnt=000 busy=0 to=1", {gnt3, gnt2, gnt1}, busy, timeout); end
        drive(3'b111, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b010 || owner !== 2'd2 || timeout !== 1'b0) begin errors++; $display("FAIL next_after_limit got gnt=%b owner=%0d to=%b exp gnt=010 owner=2 to=0", {gnt3, gnt2, gnt1}, owner, timeout); end
    endtask

    task automatic test_done();
        drive(3'b111, 1'b0);
        drive(3'b111, 1'b0);
        drive(3'b111, 1'b1);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL done_release got gnt=%b busy=%b to=%b exp gnt=000 busy=0 to=0", {gnt3, gnt2, gnt1}, busy, timeout); end
        drive(3'b111, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b100 || owner !== 2'd3) begin errors++; $display("FAIL rr_after_2 got gnt=%b owner=%0d exp gnt=100 owner=3", {gnt3, gnt2, gnt1}, owner); end
    endtask

    task automatic test_req_drop();
        drive(3'b001, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL req_drop got gnt=%b busy=%b exp gnt=000 busy=0", {gnt3, gnt2, gnt1}, busy); end
        drive(3'b001, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b001 || owner !== 2'd1) begin errors++; $display("FAIL lone_req1 got gnt=%b owner=%0d exp gnt=001 owner=1", {gnt3, gnt2, gnt1}, owner); end
    endtask

    task automatic test_limit_done();
        for (int i = 2; i <= MAX_HOLD; i++) drive(3'b001, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b001) begin errors++; $display("FAIL at_limit got gnt=%b exp gnt=001", {gnt3, gnt2, gnt1}); end
        drive(3'b001, 1'b1);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b000 || timeout !== 1'b0) begin errors++; $display("FAIL limit_with_done got gnt=%b to=%b exp gnt=000 to=0", {gnt3, gnt2, gnt1}, timeout); end
        drive(3'b000, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1, busy, timeout} !== 5'b0) begin errors++; $display("FAIL idle_after got=%b exp=00000", {gnt3, gnt2, gnt1, busy, timeout}); end
    endtask

    task automatic test_reset_mid_hold();
        drive(3'b010, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b010) begin errors++; $display("FAIL grant2 got gnt=%b exp gnt=010", {gnt3, gnt2, gnt1}); end
        drive(3'b010, 1'b0);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        checks++; if ({gnt3, gnt2, gnt1, owner, busy, timeout} !== 7'b0) begin errors++; $display("FAIL async_reset got=%b exp=0000000", {gnt3, gnt2, gnt1, owner, busy, timeout}); end
        #1 rstb = 1'b1;
        drive(3'b110, 1'b0);
        checks++; if ({gnt3, gnt2, gnt1} !== 3'b010 || owner !== 2'd2 || timeout !== 1'b0) begin errors++; $display("FAIL post_reset_rr got gnt=%b owner=%0d to=%b exp gnt=010 owner=2 to=0", {gnt3, gnt2, gnt1}, owner, timeout); end
    endtask

    task automatic test_random();
        bit [3:1] r;
        bit d;
        int wait_c [1:3];
        int run;
        logic [2:0] g;
        logic [6:0] exp_o;
        run = 0;
        for (int k = 1; k <= 3; k++) wait_c[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 1; k <= 3; k++) r[k] = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 15) == 0);
            drive(r, d);
            g = {gnt3, gnt2, gnt1};
            exp_o = model_outs();
            checks++; if ({g, owner, busy, timeout} !== exp_o) begin errors++; $display("FAIL rand_cycle%0d got=%b exp=%b", c, {g, owner, busy, timeout}, exp_o); end
            checks++; if (!$onehot0(g) || busy !== (|g)) begin errors++; $display("FAIL rand_onehot_busy cycle%0d got gnt=%b busy=%b", c, g, busy); end
            checks++; if (owner !== (g[0] ? 2'd1 : g[1] ? 2'd2 : g[2] ? 2'd3 : 2'd0)) begin errors++; $display("FAIL rand_owner cycle%0d got owner=%0d gnt=%b", c, owner, g); end
            run = busy ? run + 1 : 0;
            checks++; if (run > MAX_HOLD) begin errors++; $display("FAIL rand_hold_len cycle%0d got=%0d max=%0d", c, run, MAX_HOLD); end
            // One extra cycle allowed for a requester's own post-release dead cycle.
            for (int k = 1; k <= 3; k++) begin
                wait_c[k] = (r[k] && !g[k-1]) ? wait_c[k] + 1 : 0;
                checks++; if (wait_c[k] > 2 * (MAX_HOLD + 1) + 1) begin errors++; $display("FAIL rand_starve req%0d cycle%0d got=%0d max=%0d", k, c, wait_c[k], 2 * (MAX_HOLD + 1) + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_limit();
        test_done();
        test_req_drop();
        test_limit_done();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb3_rr.md
ARB3_RR -- requirements
Module: arb3_rr

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold the grant (legal range 2..255).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RSTB  input  1  asynchronous active-low reset; asserting it forces reset state immediately; deassertion is synchronised externally.
REQ-004 REQ1, REQ2, REQ3  input  1 each  level request from requester 1/2/3 for the shared cell resource.
REQ-005 DONE  input  1  single-cycle release strobe from the current holder; ignored when no grant is active.
REQ-006 GNT1, GNT2, GNT3  output  1 each  registered grant; at most one high in any cycle.
REQ-007 OWNER  output  2  registered index of the holder: 2'b00 none, 2'b01..2'b11 requester 1..3.
REQ-008 BUSY  output  1  registered; high exactly when any GNTn is high.
REQ-009 TIMEOUT  output  1  registered one-cycle pulse, high in the cycle after a grant is revoked by the hold limit.

Function
REQ-010 The block shall implement a two-state FSM: IDLE (no grant) and HOLD (one grant active).
REQ-011 In IDLE with at least one REQn high at a rising edge, the block shall enter HOLD and assert the winner's GNTn, OWNER and BUSY in the next cycle (1-cycle request-to-grant latency).
REQ-012 In IDLE with all REQn low, the block shall stay in IDLE with all outputs low.
REQ-013 Winner selection shall be round-robin: search order starts at the requester after the last granted one (LAST), wrapping 3->1; e.g. LAST=2 gives order 3,1,2.
REQ-014 LAST shall update to the winner on each IDLE->HOLD transition and shall be 3 after reset, so the first search order is 1,2,3.
REQ-015 In HOLD, a hold counter shall count grant cycles, starting at 1 in the first grant cycle, saturating-free within 8 bits.
REQ-016 In HOLD, the grant shall be released at a rising edge when any of: holder's REQn low, DONE high, or hold counter equal to MAX_HOLD.
REQ-017 On release the FSM shall return to IDLE; GNTn, OWNER and BUSY shall be low in the following cycle (one mandatory dead cycle between grants).
REQ-018 Re-arbitration shall take place in the dead cycle; earliest next grant is two cycles after the release edge's cycle.
REQ-019 TIMEOUT shall pulse only when release is caused solely by the hold limit; if DONE or REQn-low coincides with the limit, TIMEOUT shall stay low.
REQ-020 Requests from non-holders during HOLD shall have no effect on the grant or counter.
REQ-021 A requester whose REQn remains high after its own release shall be eligible again only by round-robin order (no immediate re-grant while others request).
REQ-022 DONE in IDLE shall be ignored and shall not affect LAST or the counter.
REQ-023 Simultaneous REQ rise of all three in IDLE shall grant exactly one, per REQ-013.

Reset
REQ-024 While RSTB is low: FSM=IDLE, LAST=3, counter=0, GNT1..3=0, OWNER=2'b00, BUSY=0, TIMEOUT=0.
REQ-025 Reset asserted mid-HOLD shall drop the grant asynchronously, without a TIMEOUT pulse, and after release arbitration shall restart per REQ-014.

Verification
REQ-026 Reset release, REQ1..3=1 at cycle 0 -> GNT1=1, OWNER=01 at cycle 1; REQ1 held, MAX_HOLD=8 -> GNT1 falls after 8 grant cycles, TIMEOUT=1 one cycle; GNT2=1 two cycles after release.
REQ-027 GNT2 active, DONE pulse at grant cycle 3 -> GNT2=0, BUSY=0 next cycle, TIMEOUT=0; with REQ1,REQ3 high, GNT3 granted next (not GNT1).
REQ-028 GNT3 active, REQ3 dropped -> grant removed next cycle; REQ1 only pending -> GNT1 after dead cycle.
REQ-029 DONE and hold-limit same edge -> release, TIMEOUT stays 0.
REQ-030 RSTB low during HOLD of requester 2 -> all outputs 0 immediately; after RSTB high with REQ2,REQ3 high -> GNT2 first.
REQ-031 Random REQ/DONE for 10000 cycles -> assertions: GNTn one-hot-or-zero, BUSY==|GNT, OWNER consistent, no grant exceeds MAX_HOLD cycles, no requester starved beyond 2*(MAX_HOLD+1) cycles.
